mtr_pwm_drv: RTL and testbench

//   Motor drive stage directly downstream of balance_cntrl. Converts signed lft_spd/rght_spd into

---
 rtl/mtr_drv_pkg.sv | 16 +
 rtl/pwm_dt_chan.sv | 102 ++++++++++
 rtl/mtr_pwm_drv.sv | 61 ++++++
 tb/tb_mtr_pwm_drv.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor PWM drive stage.
package mtr_drv_pkg;

  localparam int PWM_BITS = 11;
  localparam int SPD_W    = 12;
  localparam int NUM_CH   = 2;   // ch0 = left, ch1 = right
  localparam logic [PWM_BITS-1:0] DUTY_RST = 11'h400;

  typedef enum logic [1:0] {LOW_ON, DT_RISE, HIGH_ON, DT_FALL} dt_state_t;

  // Signed speed -> offset-binary duty; the speed LSB is below PWM resolution.
  function automatic logic [PWM_BITS-1:0] spd2duty(input logic [SPD_W-1:0] spd);
    return {~spd[SPD_W-1], spd[SPD_W-2:1]};
  endfunction

endpackage

// File: rtl/pwm_dt_chan.sv
// One half-leg: duty shadow, PWM compare, deadtime FSM, high-side on-time counter.
module pwm_dt_chan
  import mtr_drv_pkg::*;
#(
  parameter int DEAD  = 32,
  parameter int BLANK = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [SPD_W-1:0]    spd,
  input  logic                load,
  input  logic                fault,     // next-cycle fault, so gates drop on the edge it sets
  output logic                hi,
  output logic                lo,
  output logic                oc_window
);

  localparam logic [7:0] DEAD_M1 = 8'(DEAD - 1);
  localparam logic [7:0] BLANK_V = 8'(BLANK);

  logic [PWM_BITS-1:0] duty_sh;
  logic                pwm_raw;
  dt_state_t           st, st_nx;
  logic [7:0]          dcnt, dcnt_nx;
  logic [7:0]          ontime;
  logic                hi_nx, lo_nx;
  logic                spd_lsb_unused;

  assign spd_lsb_unused = spd[0];

  // Duty shadow reloads only at period end; compare output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh <= DUTY_RST;
      pwm_raw <= 1'b0;
    end else begin
      if (load) duty_sh <= spd2duty(spd);
      pwm_raw <= (cnt < duty_sh);
    end
  end

  // Deadtime FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= DT_FALL;
      dcnt <= '0;
    end else begin
      st   <= st_nx;
      dcnt <= dcnt_nx;
    end
  end

  // Next state: a PWM edge during a dead interval restarts the opposite interval.
  always_comb begin
    st_nx   = st;
    dcnt_nx = dcnt;
    unique case (st)
      LOW_ON:  if (pwm_raw) begin st_nx = DT_RISE; dcnt_nx = '0; end
      DT_RISE: begin
        if (!pwm_raw)              begin st_nx = DT_FALL; dcnt_nx = '0; end
        else if (dcnt == DEAD_M1)  st_nx = HIGH_ON;
        else                       dcnt_nx = dcnt + 8'd1;
      end
      HIGH_ON: if (!pwm_raw) begin st_nx = DT_FALL; dcnt_nx = '0; end
      DT_FALL: begin
        if (pwm_raw)               begin st_nx = DT_RISE; dcnt_nx = '0; end
        else if (dcnt == DEAD_M1)  st_nx = LOW_ON;
        else                       dcnt_nx = dcnt + 8'd1;
      end
      default: begin st_nx = DT_FALL; dcnt_nx = '0; end
    endcase
  end

  // Gate decode of next state, blanked by fault.
  always_comb begin
    hi_nx = (st_nx == HIGH_ON) && !fault;
    lo_nx = (st_nx == LOW_ON)  && !fault;
  end

  // Gate registers: change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= 1'b0;
      lo <= 1'b0;
    end else begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end

  // Saturating count of cycles spent in HIGH_ON, cleared on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   ontime <= '0;
    else if (st_nx == HIGH_ON && st != HIGH_ON) ontime <= '0;
    else if (st == HIGH_ON && ontime != 8'hFF)  ontime <= ontime + 8'd1;
  end

  // Over-current is honoured only once switching noise has settled.
  assign oc_window = (st == HIGH_ON) && (ontime >= BLANK_V);

endmodule

// File: rtl/mtr_pwm_drv.sv
// Two-channel motor gate driver: period counter, latched over-current, two deadtime channels.
module mtr_pwm_drv
  import mtr_drv_pkg::*;
#(
  parameter int DEAD  = 32,
  parameter int BLANK = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SPD_W-1:0]  lft_spd,
  input  logic [SPD_W-1:0]  rght_spd,
  input  logic              ovr_i,
  output logic              lft_hi,
  output logic              lft_lo,
  output logic              rght_hi,
  output logic              rght_lo,
  output logic              fault
);

  logic [PWM_BITS-1:0]           cnt;
  logic                          load;
  logic                          fault_nx;
  logic [NUM_CH-1:0][SPD_W-1:0]  spd;
  logic [NUM_CH-1:0]             hi, lo, ocw;

  assign spd      = {rght_spd, lft_spd};
  assign load     = &cnt;
  assign fault_nx = fault | (ovr_i & |ocw);

  // Free-running period counter; keeps counting through a fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  // Sticky over-current latch, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault <= 1'b0;
    else     fault <= fault_nx;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_dt_chan #(.DEAD(DEAD), .BLANK(BLANK)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt),
      .spd       (spd[c]),
      .load      (load),
      .fault     (fault_nx),
      .hi        (hi[c]),
      .lo        (lo[c]),
      .oc_window (ocw[c])
    );
  end

  assign lft_hi  = hi[0];
  assign lft_lo  = lo[0];
  assign rght_hi = hi[1];
  assign rght_lo = lo[1];

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Bench for mtr_pwm_drv: per-period gate on-time scoreboard, over-current and reset scenarios.
`timescale 1ns/1ps
module tb_mtr_pwm_drv;

  localparam int DEAD  = 32;
  localparam int BLANK = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] lft_spd = 12'h000;
  logic [11:0] rght_spd = 12'h000;
  logic        ovr_i = 1'b0;
  logic        lft_hi, lft_lo, rght_hi, rght_lo, fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mtr_pwm_drv #(.DEAD(DEAD), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst      (rst),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .ovr_i    (ovr_i),
    .lft_hi   (lft_hi),
    .lft_lo   (lft_lo),
    .rght_hi  (rght_hi),
    .rght_lo  (rght_lo),
    .fault    (fault)
  );

  // hi/lo of one channel must never overlap
  always @(negedge clk)
    if (!rst) assert (!(lft_hi && lft_lo) && !(rght_hi && rght_lo)) else $error("hi/lo overlap");

  typedef struct { int hl; int ll; int hr; int lr; } exp_t;  // -1 = not scored
  typedef struct { logic [11:0] l; logic [11:0] r; } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    tcnt, per, cur_dl, cur_dr;
  int    acc_hl, acc_ll, acc_hr, acc_lr, ovl, gsum;
  bit    scoring;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int duty(input logic [11:0] s);
    return int'({~s[11], s[10:1]});
  endfunction

  // Expected hi/lo clocks in a period, given the duty of the previous and current period.
  function automatic void exp_ch(input int dp, input int dc, output int h, output int l);
    h = -1; l = -1;
    if (dp == dc && dc == 0) begin h = 0; l = 2048; end
    else if (dp == dc && dc == 2047) begin h = 2047 - DEAD; l = 0; end
    else if (dp inside {[64:1984]} && dc inside {[64:1984]}) begin
      h = dc - DEAD; l = 2048 - dc - DEAD;
    end
  endfunction

  task automatic sample();
    exp_t  e;
    stim_t s;
    int    nl, nr;
    if ((lft_hi && lft_lo) || (rght_hi && rght_lo)) ovl++;
    gsum += int'(lft_hi) + int'(lft_lo) + int'(rght_hi) + int'(rght_lo);
    if (scoring) begin
      acc_hl += int'(lft_hi);  acc_ll += int'(lft_lo);
      acc_hr += int'(rght_hi); acc_lr += int'(rght_lo);
      if (tcnt == 500) begin
        if (stim_q.size() > 0) begin
          s = stim_q.pop_front();
          lft_spd = s.l; rght_spd = s.r;
        end
        nl = duty(lft_spd); nr = duty(rght_spd);
        exp_ch(cur_dl, nl, e.hl, e.ll);
        exp_ch(cur_dr, nr, e.hr, e.lr);
        exp_q.push_back(e);
        cur_dl = nl; cur_dr = nr;
      end
      if (tcnt == 2047) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 0, 1);
        else begin
          e = exp_q.pop_front();
          if (e.hl >= 0) chk($sformatf("p%0d_lft_hi", per),  acc_hl, e.hl);
          if (e.ll >= 0) chk($sformatf("p%0d_lft_lo", per),  acc_ll, e.ll);
          if (e.hr >= 0) chk($sformatf("p%0d_rght_hi", per), acc_hr, e.hr);
          if (e.lr >= 0) chk($sformatf("p%0d_rght_lo", per), acc_lr, e.lr);
        end
        chk($sformatf("p%0d_overlap", per), ovl, 0);
        acc_hl = 0; acc_ll = 0; acc_hr = 0; acc_lr = 0;
        per++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    tcnt = (tcnt + 1) % 2048;
    sample();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Reset, then release just after an edge so cnt=0 spans one full cycle.
  task automatic reset_dut();
    rst = 1'b1; ovr_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_outs", int'({lft_hi, lft_lo, rght_hi, rght_lo, fault}), 0);
    rst = 1'b0;
    tcnt = 0; per = 0; ovl = 0;
    acc_hl = 0; acc_ll = 0; acc_hr = 0; acc_lr = 0;
    cur_dl = 1024; cur_dr = 1024;
    exp_q.delete();
    // First period starts in DT_FALL, so the two lo clocks at cnt 0..1 are missing.
    exp_q.push_back('{1024 - DEAD, 2048 - 1024 - DEAD - 2, 1024 - DEAD, 2048 - 1024 - DEAD - 2});
    scoring = 1'b1;
    sample();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    stim_t s;

    // ---- PWM scoreboard: each entry takes effect the period after it is driven at cnt 500
    reset_dut();
    stim_q.push_back('{12'h000, 12'h000});   // p1 mid duty both
    stim_q.push_back('{12'h800, 12'h7FF});   // p2 transition to extremes
    stim_q.push_back('{12'h800, 12'h7FF});   // p3 steady: left never hi, right never lo
    stim_q.push_back('{12'h000, 12'h000});   // p4
    stim_q.push_back('{12'h000, 12'hC00});   // p5
    stim_q.push_back('{12'h400, 12'h000});   // p6 left 992 -> 1504
    repeat (2) begin
      do s.l = 12'($urandom_range(0, 4095)); while (!(duty(s.l) inside {[64:1984]}));
      do s.r = 12'($urandom_range(0, 4095)); while (!(duty(s.r) inside {[64:1984]}));
      stim_q.push_back(s);                   // p7, p8
    end
    stim_q.push_back('{12'h400, 12'h800});   // p9
    stim_q.push_back('{12'h400, 12'h800});   // p10 right idle for fault test
    run(2047 + 2048 * 10);
    scoring = 1'b0;
    exp_q.delete();

    // ---- over-current: ignored in LOW_ON and inside blanking, latched afterwards
    n = 0;
    while (!lft_lo && n < 4096) begin step(); n++; end
    chk("wait_lo", int'(lft_lo), 1);
    ovr_i = 1'b1; step(); ovr_i = 1'b0; step();
    chk("ovr_lo_ignored", int'(fault), 0);

    n = 0;
    while (lft_hi && n < 4096) begin step(); n++; end
    while (!lft_hi && n < 4096) begin step(); n++; end
    chk("wait_hi", int'(lft_hi), 1);             // HIGH_ON clk 0
    repeat (10) step();
    ovr_i = 1'b1; step(); ovr_i = 1'b0;
    chk("ovr_blank10", int'(fault), 0);
    repeat (52) step();                          // clk 63: last blanked clock
    ovr_i = 1'b1; step(); ovr_i = 1'b0;
    chk("ovr_blank63", int'(fault), 0);
    chk("hi_after_blank", int'(lft_hi), 1);
    repeat (36) step();                          // clk 100
    ovr_i = 1'b1; step(); ovr_i = 1'b0;
    chk("fault_set", int'(fault), 1);
    chk("fault_gates", int'({lft_hi, lft_lo, rght_hi, rght_lo}), 0);

    gsum = 0;
    run(3 * 2048);
    chk("fault_gates_held", gsum, 0);
    chk("fault_sticky", int'(fault), 1);

    // ---- reset clears fault; gates resume with reset shadow
    reset_dut();
    chk("fault_cleared", int'(fault), 0);
    stim_q.push_back('{12'h400, 12'h000});
    stim_q.push_back('{12'h400, 12'h000});
    run(2047 + 2048 + 1201);                     // lands at cnt 1200 of third period
    chk("pre_rst_hi", int'(lft_hi), 1);
    #2 rst = 1'b1;
    #1 chk("async_rst", int'({lft_hi, lft_lo, rght_hi, rght_lo, fault}), 0);
    scoring = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
